// File: rtl/adc_capture_multi.sv
// adc_capture_multi: multi-channel triggered waveform recorder.
// Every channel is written into its own ring buffer on each capture cycle.
// After arm the recorder collects a pre-trigger window, then waits for a
// trigger event, and then fills the rest of the buffer. The finished record
// is read back relative to the trigger through SampleNum/rd_ch.
module adc_capture_multi #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 14,
  parameter int DEPTH_LOG2 = 10,
  parameter int OUT_W      = 16,
  parameter int CH_W       = 1
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  input  logic                     arm,
  input  logic                     sw_trig,
  input  logic [1:0]               trig_mode,
  input  logic [CH_W-1:0]          trig_ch,
  input  logic [DATA_W-1:0]        threshold,
  input  logic [DEPTH_LOG2-1:0]    pretrig,
  input  logic [15:0]              SampleNum,
  input  logic [CH_W-1:0]          rd_ch,
  output logic [OUT_W-1:0]         waveSample,
  output logic                     busy,
  output logic                     done,
  output logic [DEPTH_LOG2-1:0]    trig_addr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  localparam logic [1:0] MODE_SW   = 2'd0;
  localparam logic [1:0] MODE_RISE = 2'd1;
  localparam logic [1:0] MODE_FALL = 2'd2;
  localparam logic [1:0] MODE_IMM  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Pre-trigger length limited to DEPTH-1 so at least the trigger sample
  // itself lands in the post-trigger part of the record.
  function automatic logic [DEPTH_LOG2-1:0] clamp_pre(input logic [DEPTH_LOG2-1:0] pre);
    logic [CNT_W-1:0] lim;
    lim = DEPTH_CNT - ONE_CNT;
    return ({1'b0, pre} > lim) ? lim[DEPTH_LOG2-1:0] : pre;
  endfunction

  // Pick one channel out of the packed sample bus; unknown channels give 0.
  function automatic logic [DATA_W-1:0] chan_sample(input logic [NUM_CH*DATA_W-1:0] bus,
                                                    input logic [CH_W-1:0]          ch);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      v = (ch == CH_W'(k)) ? bus[k*DATA_W +: DATA_W] : v;
    end
    return v;
  endfunction

  state_t                state_r;
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [DEPTH_LOG2-1:0] pre_eff_r;
  logic [1:0]            mode_r;
  logic [CH_W-1:0]       tch_r;
  logic [DATA_W-1:0]     thr_r;
  logic [DATA_W-1:0]     prev_r;
  logic                  prev_valid_r;
  logic [DEPTH_LOG2-1:0] trig_addr_r;
  logic                  busy_r;
  logic                  done_r;
  logic [OUT_W-1:0]      wave_sample_r;

  logic [DATA_W-1:0]     mem_r [NUM_CH][DEPTH];

  logic                  wr_en_s;
  logic [DATA_W-1:0]     cur_s;
  logic                  trig_s;
  logic [CNT_W-1:0]      post_len_s;
  logic [DEPTH_LOG2-1:0] rd_addr_s;
  logic [DATA_W-1:0]     rd_word_s;
  logic                  sample_num_unused_s;

  assign sample_num_unused_s = ^SampleNum[15:DEPTH_LOG2];

  assign cur_s      = chan_sample(adc_data, tch_r);
  assign post_len_s = DEPTH_CNT - {1'b0, pre_eff_r};
  assign rd_addr_s  = trig_addr_r - pre_eff_r + SampleNum[DEPTH_LOG2-1:0];

  // Buffers are written in every capture state except on the arm cycle itself.
  always_comb begin
    wr_en_s = 1'b0;
    if ((state_r == ST_PRE) || (state_r == ST_WAIT) || (state_r == ST_POST)) begin
      wr_en_s = !arm;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Trigger condition for the configuration latched at arm; prev must be valid
  // before a threshold crossing can be recognised.
  always_comb begin
    trig_s = 1'b0;
    case (mode_r)
      MODE_SW:   trig_s = sw_trig;
      MODE_RISE: trig_s = prev_valid_r && (prev_r < thr_r) && (cur_s >= thr_r);
      MODE_FALL: trig_s = prev_valid_r && (prev_r > thr_r) && (cur_s <= thr_r);
      MODE_IMM:  trig_s = 1'b1;
      default:   trig_s = 1'b0;
    endcase
  end

  // Capture sequencer: arming, pre-trigger fill, trigger wait, post fill.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      wr_ptr_r     <= '0;
      cnt_r        <= '0;
      pre_eff_r    <= '0;
      mode_r       <= 2'd0;
      tch_r        <= '0;
      thr_r        <= '0;
      prev_r       <= '0;
      prev_valid_r <= 1'b0;
      trig_addr_r  <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else if (arm) begin
      // Any arm restarts the record; the write pointer keeps running.
      mode_r       <= trig_mode;
      tch_r        <= trig_ch;
      thr_r        <= threshold;
      pre_eff_r    <= clamp_pre(pretrig);
      cnt_r        <= '0;
      prev_valid_r <= 1'b0;
      busy_r       <= 1'b1;
      done_r       <= 1'b0;
      state_r      <= (clamp_pre(pretrig) == '0) ? ST_WAIT : ST_PRE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
        end
        ST_PRE: begin
          wr_ptr_r     <= wr_ptr_r + 1'b1;
          prev_r       <= cur_s;
          prev_valid_r <= 1'b1;
          if (cnt_r == ({1'b0, pre_eff_r} - ONE_CNT)) begin
            cnt_r   <= '0;
            state_r <= ST_WAIT;
          end else begin
            cnt_r <= cnt_r + ONE_CNT;
          end
        end
        ST_WAIT: begin
          wr_ptr_r     <= wr_ptr_r + 1'b1;
          prev_r       <= cur_s;
          prev_valid_r <= 1'b1;
          if (trig_s) begin
            trig_addr_r <= wr_ptr_r;
            if (post_len_s == ONE_CNT) begin
              // The trigger sample was the only post-trigger sample.
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              cnt_r   <= ONE_CNT;
              state_r <= ST_POST;
            end
          end
        end
        ST_POST: begin
          wr_ptr_r <= wr_ptr_r + 1'b1;
          if (cnt_r == (post_len_s - ONE_CNT)) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + ONE_CNT;
          end
        end
        ST_DONE: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Ring buffer write port: all channels share the same write address.
  always_ff @(posedge sys_clk) begin
    if (wr_en_s) begin
      for (int k = 0; k < NUM_CH; k++) begin
        mem_r[k][wr_ptr_r] <= adc_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Read port: select the addressed word of the requested channel.
  always_comb begin
    rd_word_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      rd_word_s = (rd_ch == CH_W'(k)) ? mem_r[k][rd_addr_s] : rd_word_s;
    end
  end

  // Readout register, one cycle behind SampleNum/rd_ch, zero-extended.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wave_sample_r <= '0;
    end else begin
      wave_sample_r <= OUT_W'(rd_word_s);
    end
  end

  assign waveSample = wave_sample_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign trig_addr  = trig_addr_r;

endmodule
